// File: rtl/maxpool_pkg.sv
// Shared types and elaboration-time sizing helpers for the max-pooling window scheduler.
package maxpool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Number of stride-aligned window positions along one axis.
    function automatic int unsigned out_dim(input int unsigned size,
                                            input int unsigned kernel,
                                            input int unsigned stride);
        if (stride == 0 || kernel > size) return 1;
        return (size - kernel) / stride + 1;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned idx_w(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/stride_pos_counter.sv
// One axis of the raster position: pixel position, stride phase and output-grid index,
// all maintained incrementally so no divider or modulo is needed.
module stride_pos_counter
    import maxpool_pkg::*;
#(
    parameter int unsigned SIZE       = 5,
    parameter int unsigned KERNEL_DIM = 3,
    parameter int unsigned STRIDE     = 1,
    localparam int unsigned PW = cnt_w(SIZE),
    localparam int unsigned HW = cnt_w(STRIDE),
    localparam int unsigned IW = idx_w(out_dim(SIZE, KERNEL_DIM, STRIDE))
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [PW-1:0] pos,
    output logic          wrap_c,
    output logic [HW-1:0] phase,
    output logic          aligned_c,
    output logic [IW-1:0] idx
);

    logic [PW-1:0] pos_nxt;
    logic [HW-1:0] phase_nxt;
    logic [IW-1:0] idx_nxt;

    assign wrap_c    = (pos == PW'(SIZE - 1));
    assign aligned_c = (pos >= PW'(KERNEL_DIM - 1)) && (phase == '0);

    // Phase and index stay at zero up to the first full window, then step with the stride.
    always_comb begin
        pos_nxt   = wrap_c ? '0 : pos + PW'(1);
        phase_nxt = '0;
        idx_nxt   = '0;
        if (pos_nxt > PW'(KERNEL_DIM - 1)) begin
            phase_nxt = (phase == HW'(STRIDE - 1)) ? '0 : phase + HW'(1);
            idx_nxt   = (phase_nxt == '0) ? idx + IW'(1) : idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pos   <= '0;
            phase <= '0;
            idx   <= '0;
        end else if (clr) begin
            pos   <= '0;
            phase <= '0;
            idx   <= '0;
        end else if (en) begin
            pos   <= pos_nxt;
            phase <= phase_nxt;
            idx   <= idx_nxt;
        end
    end

endmodule

// File: rtl/pool_window_sched.sv
// Frame controller for the max-pooling sliding window: pixel handshake, shift enable,
// stride-aligned window flagging toward the reducer, and frame completion.
module pool_window_sched
    import maxpool_pkg::*;
#(
    parameter int unsigned ROW_SIZE   = 5,
    parameter int unsigned COL_SIZE   = 5,
    parameter int unsigned KERNEL_DIM = 3,
    parameter int unsigned STRIDE     = 1,
    localparam int unsigned OUT_W = out_dim(ROW_SIZE, KERNEL_DIM, STRIDE),
    localparam int unsigned OUT_H = out_dim(COL_SIZE, KERNEL_DIM, STRIDE),
    localparam int unsigned CW    = idx_w(OUT_W),
    localparam int unsigned RW    = idx_w(OUT_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    output logic          win_clear,
    output logic          pool_valid,
    input  logic          pool_ready,
    output logic [RW-1:0] pool_row,
    output logic [CW-1:0] pool_col,
    output logic          busy,
    output logic          frame_done
);

    localparam int unsigned CPW = cnt_w(ROW_SIZE);
    localparam int unsigned RPW = cnt_w(COL_SIZE);
    localparam int unsigned HW  = cnt_w(STRIDE);

    if (STRIDE < 1 || STRIDE > KERNEL_DIM || KERNEL_DIM > ROW_SIZE || KERNEL_DIM > COL_SIZE) begin : g_param_check
        $error("pool_window_sched: STRIDE must be 1..KERNEL_DIM and KERNEL_DIM <= image size");
    end

    state_t state, state_nxt;

    logic [CPW-1:0] col_pos;
    logic [RPW-1:0] row_pos;
    logic [HW-1:0]  col_phase, row_phase;
    logic [CW-1:0]  col_idx;
    logic [RW-1:0]  row_idx;
    logic           col_wrap, row_wrap, col_aligned, row_aligned;
    logic           clr_c, pool_hs_c, last_px_c, qualify_c;

    assign in_ready  = (state == RUN) && (!pool_valid || pool_ready);
    assign shift_en  = in_valid && in_ready;
    assign clr_c     = (state == CLEAR);
    assign pool_hs_c = pool_valid && pool_ready;
    assign last_px_c = shift_en && col_wrap && row_wrap;
    assign qualify_c = shift_en && col_aligned && row_aligned;

    stride_pos_counter #(
        .SIZE(ROW_SIZE), .KERNEL_DIM(KERNEL_DIM), .STRIDE(STRIDE)
    ) u_col (
        .clk(clk), .rst(rst), .clr(clr_c), .en(shift_en),
        .pos(col_pos), .wrap_c(col_wrap), .phase(col_phase),
        .aligned_c(col_aligned), .idx(col_idx)
    );

    stride_pos_counter #(
        .SIZE(COL_SIZE), .KERNEL_DIM(KERNEL_DIM), .STRIDE(STRIDE)
    ) u_row (
        .clk(clk), .rst(rst), .clr(clr_c), .en(shift_en && col_wrap),
        .pos(row_pos), .wrap_c(row_wrap), .phase(row_phase),
        .aligned_c(row_aligned), .idx(row_idx)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = RUN;
            RUN:     if (last_px_c) state_nxt = DRAIN;
            DRAIN:   if (!pool_valid || pool_hs_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A newly qualifying pixel takes priority over retiring the current window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            win_clear  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            pool_valid <= 1'b0;
            pool_row   <= '0;
            pool_col   <= '0;
        end else begin
            state      <= state_nxt;
            win_clear  <= (state == IDLE) && start;
            busy       <= (state_nxt != IDLE);
            frame_done <= (state == DRAIN) && (state_nxt == IDLE);
            if (qualify_c) begin
                pool_valid <= 1'b1;
                pool_row   <= row_idx;
                pool_col   <= col_idx;
            end else if (pool_hs_c) begin
                pool_valid <= 1'b0;
            end
        end
    end

    a_counter_range: assert property (@(posedge clk) disable iff (!rst)
        (32'(col_pos) < ROW_SIZE) && (32'(row_pos) < COL_SIZE) &&
        (32'(col_phase) < STRIDE) && (32'(row_phase) < STRIDE));

endmodule

// File: tb/tb_pool_window_sched.sv
// Directed bench for pool_window_sched: default 3x3/stride-1 and stride-2 instances on a 5x5 frame.
module tb_pool_window_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic pool_ready = 1'b1;

    logic       a_in_ready, a_shift_en, a_win_clear, a_pool_valid, a_busy, a_frame_done;
    logic [2:0] a_pool_row, a_pool_col;
    logic       b_in_ready, b_shift_en, b_win_clear, b_pool_valid, b_busy, b_frame_done;
    logic [1:0] b_pool_row, b_pool_col;

    int n_checks = 0;
    int n_errors = 0;
    int sel = 0;
    int cyc = 0, acc = 0, n_wc = 0, n_fd = 0;
    int wc_cyc = -1, st_cyc = -1, fd_cyc = -1, last_flag_cyc = -1;
    int bad_shift = 0, held_shift = 0;
    int fl_px[$], fl_rc[$], e_px[$], e_rc[$];
    int done;

    always #5 clk = ~clk;

    pool_window_sched u_dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(a_in_ready),
        .shift_en(a_shift_en), .win_clear(a_win_clear), .pool_valid(a_pool_valid),
        .pool_ready(pool_ready), .pool_row(a_pool_row), .pool_col(a_pool_col),
        .busy(a_busy), .frame_done(a_frame_done)
    );

    pool_window_sched #(.STRIDE(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_in_ready),
        .shift_en(b_shift_en), .win_clear(b_win_clear), .pool_valid(b_pool_valid),
        .pool_ready(pool_ready), .pool_row(b_pool_row), .pool_col(b_pool_col),
        .busy(b_busy), .frame_done(b_frame_done)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Mid-cycle monitor on the selected instance; a flag is logged with the pixel count before this cycle.
    initial begin : mon
        logic v, sh, wc, fd;
        int   rc;
        forever begin
            @(negedge clk);
            if (sel == 0) begin
                v = a_pool_valid; sh = a_shift_en; wc = a_win_clear; fd = a_frame_done;
                rc = int'(a_pool_row) * 16 + int'(a_pool_col);
            end else begin
                v = b_pool_valid; sh = b_shift_en; wc = b_win_clear; fd = b_frame_done;
                rc = int'(b_pool_row) * 16 + int'(b_pool_col);
            end
            cyc++;
            if (start && st_cyc < 0) st_cyc = cyc;
            if (v && pool_ready) begin
                fl_px.push_back(acc);
                fl_rc.push_back(rc);
                last_flag_cyc = cyc;
            end
            if (sh && !in_valid) bad_shift++;
            if (sh && v && !pool_ready) held_shift++;
            if (sh) acc++;
            if (wc) begin n_wc++; wc_cyc = cyc; end
            if (fd) begin n_fd++; fd_cyc = cyc; end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        acc = 0; n_wc = 0; n_fd = 0;
        wc_cyc = -1; st_cyc = -1; fd_cyc = -1; last_flag_cyc = -1;
        bad_shift = 0; held_shift = 0;
        fl_px.delete(); fl_rc.delete();
    endtask

    task automatic exp_default();
        e_px = '{13, 14, 15, 18, 19, 20, 23, 24, 25};
        e_rc = '{0, 1, 2, 16, 17, 18, 32, 33, 34};
    endtask

    task automatic compare_flags(input string tag);
        check({tag, "_nflags"}, fl_px.size(), e_px.size());
        for (int i = 0; i < e_px.size(); i++) begin
            int ap = (i < fl_px.size()) ? fl_px[i] : -1;
            int ar = (i < fl_rc.size()) ? fl_rc[i] : -1;
            check($sformatf("%s_px%0d", tag, i), ap, e_px[i]);
            check($sformatf("%s_rc%0d", tag, i), ar, e_rc[i]);
        end
    endtask

    // mode 0: back-to-back, 1: in_valid toggling, 2: hold pool_ready low 3 cycles at first flag
    task automatic run_frame(input int mode, input int stop_at, input int start_at, output int fin);
        int held = 0;
        int pulsed = 0;
        int snap;
        fin = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (n_fd > 0) begin fin = 1; break; end
            if (stop_at > 0 && acc >= stop_at) break;
            in_valid = (acc < 25) && (mode != 1 || (c % 2) == 0);
            if (mode == 2 && held == 0 && a_pool_valid) begin
                held = 1;
                pool_ready = 1'b0;
                snap = int'({a_pool_row, a_pool_col});
                check("bp_first_coord", snap, 0);
                for (int h = 0; h < 3; h++) begin
                    #1;
                    check("bp_in_ready", int'(a_in_ready), 0);
                    check("bp_coord", int'({a_pool_row, a_pool_col}), snap);
                    step();
                end
                pool_ready = 1'b1;
            end
            if (start_at > 0 && pulsed == 0 && acc >= start_at) begin
                start = 1'b1;
                pulsed = 1;
            end
            step();
            start = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #3 rst = 1'b0;
        #1;
        check("reset_a", int'({a_in_ready, a_shift_en, a_win_clear, a_pool_valid, a_busy,
                               a_frame_done, a_pool_row, a_pool_col}), 0);
        check("reset_b", int'({b_in_ready, b_shift_en, b_win_clear, b_pool_valid, b_busy,
                               b_frame_done, b_pool_row, b_pool_col}), 0);
        step(); step();
        rst = 1'b1;
        step();

        // default frame, pool_ready tied high
        sel = 0; clr_mon();
        run_frame(0, 0, 0, done);
        repeat (3) step();
        check("t1_done", done, 1);
        check("t1_wc_latency", wc_cyc - st_cyc, 1);
        check("t1_n_wc", n_wc, 1);
        exp_default();
        compare_flags("t1");
        check("t1_n_fd", n_fd, 1);
        check("t1_fd_after_flag", fd_cyc - last_flag_cyc, 1);
        check("t1_pixels", acc, 25);
        check("t1_busy_idle", int'(a_busy), 0);

        // stride 2 instance
        sel = 1; clr_mon();
        run_frame(0, 0, 0, done);
        repeat (3) step();
        check("t2_done", done, 1);
        e_px = '{13, 15, 23, 25};
        e_rc = '{0, 1, 16, 17};
        compare_flags("t2");
        check("t2_n_fd", n_fd, 1);

        // reducer backpressure at the first flag
        sel = 0; clr_mon();
        run_frame(2, 0, 0, done);
        repeat (3) step();
        check("t3_done", done, 1);
        check("t3_held_shift", held_shift, 0);
        check("t3_pixels", acc, 25);
        exp_default();
        compare_flags("t3");

        // source gaps every other cycle
        clr_mon();
        run_frame(1, 0, 0, done);
        repeat (3) step();
        check("t4_done", done, 1);
        check("t4_bad_shift", bad_shift, 0);
        check("t4_pixels", acc, 25);
        compare_flags("t4");

        // reset mid-frame after pixel 16
        clr_mon();
        run_frame(0, 16, 0, done);
        check("t5_busy_before", int'(a_busy), 1);
        rst = 1'b0;
        #1;
        check("t5_reset_a", int'({a_in_ready, a_shift_en, a_win_clear, a_pool_valid, a_busy,
                                  a_frame_done, a_pool_row, a_pool_col}), 0);
        check("t5_reset_b", int'({b_in_ready, b_shift_en, b_win_clear, b_pool_valid, b_busy,
                                  b_frame_done, b_pool_row, b_pool_col}), 0);
        repeat (4) step();
        check("t5_no_fd", n_fd, 0);
        rst = 1'b1;
        step();
        clr_mon();
        run_frame(0, 0, 0, done);
        repeat (3) step();
        check("t5_done", done, 1);
        compare_flags("t5");

        // start during RUN is ignored
        clr_mon();
        run_frame(0, 0, 5, done);
        repeat (3) step();
        check("t6_done", done, 1);
        check("t6_n_wc", n_wc, 1);
        check("t6_n_fd", n_fd, 1);
        compare_flags("t6");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pool_window_sched.md
Name: pool_window_sched

Overview:
- Frame-level controller for the max-pooling sliding-window datapath.
- Accepts a raster pixel stream through a valid/ready handshake and drives the window's shift enable.
- Tracks row and column position, and flags the stride-aligned complete windows that the pooling reducer consumes.
- Applies downstream backpressure to the pixel source and reports frame completion.

Parameters:
- ROW_SIZE, 5, image width in pixels
- COL_SIZE, 5, image height in pixels
- KERNEL_DIM, 3, pooling window edge (matches the sliding-window datapath)
- STRIDE, 1, window step in both axes (1..KERNEL_DIM)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; arms a new frame when idle
- in_valid  in  1  source presents a pixel
- in_ready  out  1  controller accepts a pixel this cycle
- shift_en  out  1  advance the sliding window by one pixel; equals in_valid & in_ready
- win_clear  out  1  one-cycle pulse that clears window/line-buffer contents at frame start
- pool_valid  out  1  current window is complete and stride-aligned
- pool_ready  in  1  reducer consumes the window
- pool_row  out  $clog2(OUT_H)+1  output-grid row of the flagged window
- pool_col  out  $clog2(OUT_W)+1  output-grid column of the flagged window
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when the frame completes

Behaviour:
- Derived widths: OUT_W = (ROW_SIZE-KERNEL_DIM)/STRIDE+1 and OUT_H = (COL_SIZE-KERNEL_DIM)/STRIDE+1, integer division.
- Reset (rst low, asynchronous): state IDLE; all counters 0; in_ready, shift_en, win_clear, pool_valid, busy and frame_done all 0; pool_row and pool_col 0.
- States:
  - IDLE: start -> CLEAR.
  - CLEAR: drive win_clear=1 for one cycle -> RUN.
  - RUN: accept pixels. When the last pixel (row COL_SIZE-1, col ROW_SIZE-1) is accepted -> DRAIN.
  - DRAIN: wait until pool_valid is 0 or a pool_valid & pool_ready handshake occurs; then pulse frame_done -> IDLE.
- busy=1 in CLEAR, RUN and DRAIN. start outside IDLE is ignored.
- in_ready = (state==RUN) & (!pool_valid | pool_ready). Acceptance and pool handshake may occur in the same cycle.
- Position counters col (0..ROW_SIZE-1) and row (0..COL_SIZE-1):
  - Advance on every accepted pixel.
  - col wraps to 0 and row increments at col==ROW_SIZE-1.
  - Both clear in CLEAR.
- Stride phase counters (0..STRIDE-1):
  - Phase resets to 0 when its position counter equals KERNEL_DIM-1.
  - Phase increments and wraps on each advance beyond that point.
  - No modulo or divide hardware.
- Window qualification, with latency 1:
  - The pixel accepted at edge N is the bottom-right of the window visible after edge N.
  - pool_valid goes high after edge N iff row>=KERNEL_DIM-1, col>=KERNEL_DIM-1 and both phases are 0 at acceptance.
- pool_valid holds, with pool_row and pool_col stable, until pool_ready.
- pool_valid clears on handshake unless a new qualifying pixel is accepted in the same cycle; in that case it stays 1 with updated coordinates.
- pool_row and pool_col are output-grid indices (window index along each axis), incremented by the stride phase logic rather than computed by division.
- Pixels in the trailing columns/rows not covered by a full stride step (for example STRIDE=2, ROW_SIZE=6) are accepted and shifted but never flagged.
- Reset mid-frame returns everything to IDLE immediately. The partial frame is discarded with no frame_done.
- Assertion (sim only): STRIDE must lie in 1..KERNEL_DIM, and KERNEL_DIM must not exceed ROW_SIZE or COL_SIZE.

Decomposition:
- Package maxpool_pkg holds:
  - the state enum (IDLE, CLEAR, RUN, DRAIN);
  - constant functions for OUT_W, OUT_H and counter widths.
- Sub-module stride_pos_counter (parameters: SIZE, KERNEL_DIM, STRIDE). It provides:
  - position counter;
  - wrap flag;
  - stride phase;
  - aligned flag;
  - output index.
- stride_pos_counter is instantiated once per axis; the row instance is enabled by the column wrap.

Test Plan:
- Defaults, pool_ready tied 1, pixels 1..25 streamed back-to-back after start:
  - win_clear is seen 1 cycle after start.
  - pool_valid is first seen 1 cycle after pixel 13 is accepted, with (row,col)=(0,0).
  - Flags follow pixels 13,14,15,18,19,20,23,24,25, nine total.
  - frame_done pulses after the last flag.
- STRIDE=2, KERNEL_DIM=3, 5x5:
  - Exactly four flags, after pixels 13,15,23,25, at coordinates (0,0),(0,1),(1,0),(1,1).
- Backpressure: pool_ready held 0 for 3 cycles at the first flag:
  - in_ready stays 0 and pool_row/pool_col stay stable.
  - No shift_en pulses while held.
  - The stream resumes with no pixel lost; the flag count is still 9.
- Source gaps: in_valid toggled 1/0 each cycle:
  - The flag sequence and coordinates are identical to test 1.
  - shift_en is high only on accepted cycles.
- Reset asserted after pixel 16:
  - All outputs return to 0 asynchronously with no frame_done.
  - A following start plus 25 pixels produces the full nine-flag frame.
- start pulsed during RUN is ignored:
  - No win_clear and no counter reset; the frame completes normally.
